triangulo_ctrl: RTL



---
 rtl/triangulo_ctrl_if.sv | 31 +++
 rtl/triangulo_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/triangulo_ctrl_if.sv
// Key, frame tick and committed-vertex bundle between
// the board, the VGA timing generator and the renderer.
interface triangulo_ctrl_if;
  logic [3:0]  KEY;
  logic        frame_tick;
  logic [10:0] ponto1_x;
  logic [9:0]  ponto1_y;
  logic [10:0] ponto2_x;
  logic [9:0]  ponto2_y;
  logic [10:0] ponto3_x;
  logic [9:0]  ponto3_y;
  logic [1:0]  sel;
  logic        axis;
  logic        updated;

  modport slave (
    input  KEY, frame_tick,
    output ponto1_x, ponto1_y,
    output ponto2_x, ponto2_y,
    output ponto3_x, ponto3_y,
    output sel, axis, updated
  );

  modport master (
    output KEY, frame_tick,
    input  ponto1_x, ponto1_y,
    input  ponto2_x, ponto2_y,
    input  ponto3_x, ponto3_y,
    input  sel, axis, updated
  );
endinterface

// File: rtl/triangulo_ctrl.sv
// Push-button vertex editor; working edits are copied
// to the renderer outputs only on a frame tick.
module triangulo_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int STEP  = 8,
  parameter int X_MIN = 285,
  parameter int X_MAX = 1554,
  parameter int Y_MIN = 35,
  parameter int Y_MAX = 514
) (
  input  logic CLOCK_50,
  input  logic RESET,
  triangulo_ctrl_if.slave bus
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic signed [11:0] STP = 12'(STEP);
  localparam logic signed [11:0] XLO = 12'(X_MIN);
  localparam logic signed [11:0] XHI = 12'(X_MAX);
  localparam logic signed [11:0] YLO = 12'(Y_MIN);
  localparam logic signed [11:0] YHI = 12'(Y_MAX);

  typedef enum logic {IDLE, APPLY} state_t;

  state_t state, state_n;

  logic [3:0]    s1, s2, db, ev;
  logic [CW-1:0] cnt [4];

  logic [10:0] wx [3];
  logic [9:0]  wy [3];
  logic [10:0] cx [3];
  logic [9:0]  cy [3];

  logic [1:0] sel, sel_n;
  logic       axis, axis_n;
  logic       dir, dir_n;
  logic       wr, dirty, updated;

  logic signed [11:0] cur, sum, lo, hi, res;

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      s1 <= 4'hF;
      s2 <= 4'hF;
      db <= 4'hF;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      s1 <= bus.KEY;
      s2 <= s1;
      for (int i = 0; i < 4; i++) begin
        if (s2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == LAST) begin
          db[i]  <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // a press is the debounced level about to fall
  always_comb begin
    for (int i = 0; i < 4; i++)
      ev[i] = db[i] & ~s2[i] & (cnt[i] == LAST);
  end

  always_comb begin
    state_n = state;
    sel_n   = sel;
    axis_n  = axis;
    dir_n   = dir;
    wr      = 1'b0;
    case (state)
      IDLE: begin
        priority case (1'b1)
          ev[0]: sel_n = (sel == 2'd2) ? 2'd0 : sel + 2'd1;
          ev[3]: axis_n = ~axis;
          ev[1]: begin dir_n = 1'b0; state_n = APPLY; end
          ev[2]: begin dir_n = 1'b1; state_n = APPLY; end
          default: ;
        endcase
      end
      APPLY: begin
        wr      = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    cur = '0;
    for (int i = 0; i < 3; i++)
      if (sel == 2'(i))
        cur = axis ? $signed({2'b00, wy[i]})
                   : $signed({1'b0, wx[i]});
    lo  = axis ? YLO : XLO;
    hi  = axis ? YHI : XHI;
    sum = dir ? cur + STP : cur - STP;
    if (dir) res = (sum > hi) ? hi : sum;
    else     res = (sum < lo) ? lo : sum;
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state   <= IDLE;
      sel     <= 2'd0;
      axis    <= 1'b0;
      dir     <= 1'b0;
      dirty   <= 1'b0;
      updated <= 1'b0;
      wx[0] <= 11'd400;  wy[0] <= 10'd80;
      wx[1] <= 11'd700;  wy[1] <= 10'd500;
      wx[2] <= 11'd1200; wy[2] <= 10'd450;
      cx[0] <= 11'd400;  cy[0] <= 10'd80;
      cx[1] <= 11'd700;  cy[1] <= 10'd500;
      cx[2] <= 11'd1200; cy[2] <= 10'd450;
    end else begin
      state   <= state_n;
      sel     <= sel_n;
      axis    <= axis_n;
      dir     <= dir_n;
      updated <= bus.frame_tick & dirty;
      if (bus.frame_tick && dirty) begin
        for (int i = 0; i < 3; i++) begin
          cx[i] <= wx[i];
          cy[i] <= wy[i];
        end
      end
      // a write racing a commit keeps dirty for the next tick
      if (wr) begin
        dirty <= 1'b1;
        for (int i = 0; i < 3; i++) begin
          if (sel == 2'(i)) begin
            if (axis) wy[i] <= 10'(res);
            else      wx[i] <= 11'(res);
          end
        end
      end else if (bus.frame_tick) begin
        dirty <= 1'b0;
      end
    end
  end

  assign bus.ponto1_x = cx[0];
  assign bus.ponto1_y = cy[0];
  assign bus.ponto2_x = cx[1];
  assign bus.ponto2_y = cy[1];
  assign bus.ponto3_x = cx[2];
  assign bus.ponto3_y = cy[2];
  assign bus.sel      = sel;
  assign bus.axis     = axis;
  assign bus.updated  = updated;

endmodule
